// File: rtl/eth_frame_gen.sv
// Ethernet test-frame generator: emits preamble/SFD, header, patterned payload,
// zero pad and CRC32 FCS on the MAC transmit byte interface, honouring sink ready.
module eth_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0102_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h0800,
  parameter int          PREAMBLE  = 1,
  parameter int          GAP       = 12,
  parameter int          LEN_W     = 11
) (
  input  logic             mac_tx_clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [15:0]      frame_count_i,
  input  logic [LEN_W-1:0] payload_len_i,
  input  logic [1:0]       pattern_i,
  input  logic             mac_tx_rdy_i,
  output logic [7:0]       mac_tx_data,
  output logic             mac_tx_valid,
  output logic             mac_tx_sof,
  output logic             mac_tx_eof,
  output logic             busy_o,
  output logic [31:0]      frames_sent_o
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP} state_t;

  localparam state_t       FIRST_STATE = (PREAMBLE != 0) ? S_PRE : S_HDR;
  localparam logic [111:0] HDR_WORD    = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]  CRC_POLY    = 32'h04C1_1DB7;

  state_t       state, state_nx;
  logic [10:0]  cnt, cnt_nx;
  logic [31:0]  crc, crc_nx, fcs;
  logic [10:0]  run_len, len_clamped;
  logic [1:0]   run_pattern;
  logic [15:0]  run_count, run_sent;
  logic         stop_pend, xfer, last_frame, eof_xfer;
  logic [111:0] hdr_sh;
  logic [7:0]   data_nx;
  logic         valid_nx, sof_nx, eof_nx;

  // MSB-first CRC with data fed LSB first, the bit order of the serial line
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign len_clamped = (32'(payload_len_i) > 32'd1500) ? 11'd1500 : 11'(payload_len_i);
  assign xfer        = mac_tx_valid && mac_tx_rdy_i;
  assign last_frame  = (run_count != 16'd0) && (run_sent + 16'd1 == run_count);
  assign eof_xfer    = xfer && (state == S_FCS) && (cnt == 11'd3);

  always_ff @(posedge mac_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (start_i) begin
        state_nx = FIRST_STATE;
        cnt_nx   = '0;
      end
      S_PRE: if (xfer) begin
        if (cnt == 11'd7) begin state_nx = S_HDR; cnt_nx = '0; end
        else cnt_nx = cnt + 11'd1;
      end
      S_HDR: if (xfer) begin
        if (cnt == 11'd13) begin
          state_nx = (run_len == 11'd0) ? S_PAD : S_PAY;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 11'd1;
      end
      S_PAY: if (xfer) begin
        if (cnt == run_len - 11'd1) begin
          state_nx = (run_len < 11'd46) ? S_PAD : S_FCS;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 11'd1;
      end
      S_PAD: if (xfer) begin
        if (cnt == 11'd45 - run_len) begin state_nx = S_FCS; cnt_nx = '0; end
        else cnt_nx = cnt + 11'd1;
      end
      S_FCS: if (xfer) begin
        if (cnt == 11'd3) begin
          state_nx = (stop_i || last_frame) ? S_IDLE : S_GAP;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 11'd1;
      end
      S_GAP: begin
        if (cnt == 11'(GAP - 1)) begin
          state_nx = (stop_pend || stop_i) ? S_IDLE : FIRST_STATE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 11'd1;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // CRC is seeded whenever a header is about to start and frozen while FCS goes out
  always_comb begin
    crc_nx = crc;
    case (state)
      S_HDR, S_PAY, S_PAD: if (xfer) crc_nx = crc_byte(crc, mac_tx_data);
      S_FCS:               crc_nx = crc;
      default:             crc_nx = '1;
    endcase
    for (int i = 0; i < 32; i++) fcs[i] = ~crc_nx[31 - i];
  end

  // Outputs are derived from the next byte position so they can be registered
  always_comb begin
    hdr_sh  = HDR_WORD << {cnt_nx[3:0], 3'b000};
    data_nx = 8'h00;
    case (state_nx)
      S_PRE: data_nx = (cnt_nx == 11'd7) ? 8'hD5 : 8'h55;
      S_HDR: data_nx = hdr_sh[111:104];
      S_PAY: begin
        case (run_pattern)
          2'd0:    data_nx = 8'h00;
          2'd1:    data_nx = cnt_nx[7:0];
          2'd2:    data_nx = run_sent[7:0];
          default: data_nx = 8'hA5;
        endcase
      end
      S_FCS:   data_nx = 8'(fcs >> {cnt_nx[1:0], 3'b000});
      default: data_nx = 8'h00;
    endcase
    valid_nx = (state_nx != S_IDLE) && (state_nx != S_GAP);
    sof_nx   = (state_nx == FIRST_STATE) && (cnt_nx == 11'd0);
    eof_nx   = (state_nx == S_FCS) && (cnt_nx == 11'd3);
  end

  always_ff @(posedge mac_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc           <= '1;
      run_len       <= '0;
      run_pattern   <= '0;
      run_count     <= '0;
      run_sent      <= '0;
      stop_pend     <= 1'b0;
      frames_sent_o <= '0;
      mac_tx_data   <= '0;
      mac_tx_valid  <= 1'b0;
      mac_tx_sof    <= 1'b0;
      mac_tx_eof    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      crc          <= crc_nx;
      mac_tx_data  <= data_nx;
      mac_tx_valid <= valid_nx;
      mac_tx_sof   <= sof_nx;
      mac_tx_eof   <= eof_nx;
      busy_o       <= (state_nx != S_IDLE);
      if (state == S_IDLE && start_i) begin
        run_len     <= len_clamped;
        run_pattern <= pattern_i;
        run_count   <= frame_count_i;
        run_sent    <= '0;
      end
      if (eof_xfer) begin
        run_sent      <= run_sent + 16'd1;
        frames_sent_o <= frames_sent_o + 32'd1;
      end
      if (state == S_GAP) begin
        if (stop_i) stop_pend <= 1'b1;
      end else begin
        stop_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: a frame-level reference model is compared with the
// DUT every cycle, under random ready, plus literal spot checks on captured bytes.
`timescale 1ns/1ps
module tb_eth_frame_gen;

  localparam int          GAP_CYC = 12;
  localparam logic [47:0] DST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC     = 48'h0102_0304_0506;
  localparam logic [15:0] ETYPE   = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sel = 1'b0, rdy_rand = 1'b0;
  logic        rdy = 1'b1;
  logic [15:0] frame_count = '0;
  logic [10:0] payload_len = '0;
  logic [1:0]  pattern = '0;

  logic [7:0]  a_data, b_data, data;
  logic        a_valid, a_sof, a_eof, a_busy, b_valid, b_sof, b_eof, b_busy;
  logic        valid, sof, eof, busy;
  logic [31:0] a_sent, b_sent, sent;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_frame_gen #(.PREAMBLE(1), .GAP(GAP_CYC)) u_dut_pre (
    .mac_tx_clk(clk), .rst_n(rst_n), .start_i(start && !sel), .stop_i(stop),
    .frame_count_i(frame_count), .payload_len_i(payload_len), .pattern_i(pattern),
    .mac_tx_rdy_i(rdy), .mac_tx_data(a_data), .mac_tx_valid(a_valid),
    .mac_tx_sof(a_sof), .mac_tx_eof(a_eof), .busy_o(a_busy), .frames_sent_o(a_sent)
  );

  eth_frame_gen #(.PREAMBLE(0), .GAP(GAP_CYC)) u_dut_nopre (
    .mac_tx_clk(clk), .rst_n(rst_n), .start_i(start && sel), .stop_i(stop),
    .frame_count_i(frame_count), .payload_len_i(payload_len), .pattern_i(pattern),
    .mac_tx_rdy_i(rdy), .mac_tx_data(b_data), .mac_tx_valid(b_valid),
    .mac_tx_sof(b_sof), .mac_tx_eof(b_eof), .busy_o(b_busy), .frames_sent_o(b_sent)
  );

  assign data  = sel ? b_data  : a_data;
  assign valid = sel ? b_valid : a_valid;
  assign sof   = sel ? b_sof   : a_sof;
  assign eof   = sel ? b_eof   : a_eof;
  assign busy  = sel ? b_busy  : a_busy;
  assign sent  = sel ? b_sent  : a_sent;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole frames are built as byte lists, then walked byte by byte
  typedef enum {M_IDLE, M_FRAME, M_GAP} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [7:0]  m_frame[$];
  logic [7:0]  cap[$];
  logic [7:0]  ref_q[$];
  int          m_pos = 0, m_gap = 0, m_idx = 0, m_len = 0, m_pat = 0, m_cnt = 0, m_pre = 1;
  bit          m_stop_pend = 0;
  int unsigned m_sent[2] = '{0, 0};

  function automatic logic [31:0] crc_reflect(input logic [7:0] q[$], input int from, input int to);
    logic [31:0] r;
    r = '1;
    for (int i = from; i < to; i++) begin
      r ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] residue(input logic [7:0] q[$], input int from, input int to);
    logic [31:0] r, n;
    r = crc_reflect(q, from, to);
    for (int i = 0; i < 32; i++) n[i] = r[31 - i];
    return n;
  endfunction

  function automatic void build_frame(input int pre, input int len, input int pat, input int idx);
    logic [31:0] f;
    m_frame.delete();
    if (pre != 0) begin
      repeat (7) m_frame.push_back(8'h55);
      m_frame.push_back(8'hD5);
    end
    for (int i = 0; i < 6; i++) m_frame.push_back(8'(DST >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) m_frame.push_back(8'(SRC >> (40 - 8 * i)));
    m_frame.push_back(ETYPE[15:8]);
    m_frame.push_back(ETYPE[7:0]);
    for (int k = 0; k < len; k++)
      case (pat)
        0:       m_frame.push_back(8'h00);
        1:       m_frame.push_back(8'(k));
        2:       m_frame.push_back(8'(idx));
        default: m_frame.push_back(8'hA5);
      endcase
    for (int k = len; k < 46; k++) m_frame.push_back(8'h00);
    f = ~crc_reflect(m_frame, (pre != 0) ? 8 : 0, m_frame.size());
    for (int b = 0; b < 4; b++) m_frame.push_back(8'(f >> (8 * b)));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("reset_outputs", {data, valid, sof, eof, busy, sent}, 64'd0);
      m_state = M_IDLE;
      m_sent  = '{0, 0};
    end else begin
      case (m_state)
        M_IDLE:  check_output("idle_ctrl", {valid, sof, eof, busy}, 4'b0000);
        M_GAP:   check_output("gap_ctrl", {valid, sof, eof, busy}, 4'b0001);
        default: check_output($sformatf("frame_byte f%0d b%0d", m_idx, m_pos),
                   {valid, sof, eof, busy, data},
                   {1'b1, m_pos == 0, m_pos == m_frame.size() - 1, 1'b1, m_frame[m_pos]});
      endcase
      check_output("frames_sent", sent, m_sent[sel]);
      case (m_state)
        M_IDLE: if (start) begin
          m_len = (payload_len > 11'd1500) ? 1500 : int'(payload_len);
          m_pat = pattern;
          m_cnt = frame_count;
          m_pre = sel ? 0 : 1;
          m_idx = 0;
          build_frame(m_pre, m_len, m_pat, m_idx);
          m_pos   = 0;
          m_state = M_FRAME;
        end
        M_FRAME: if (rdy) begin
          cap.push_back(data);
          if (m_pos == m_frame.size() - 1) begin
            m_sent[sel]++;
            m_idx++;
            if (stop || (m_cnt != 0 && m_idx == m_cnt)) m_state = M_IDLE;
            else begin
              m_state     = M_GAP;
              m_gap       = 0;
              m_stop_pend = 0;
            end
          end else m_pos++;
        end
        default: begin
          if (stop) m_stop_pend = 1;
          m_gap++;
          if (m_gap == GAP_CYC) begin
            if (m_stop_pend) m_state = M_IDLE;
            else begin
              build_frame(m_pre, m_len, m_pat, m_idx);
              m_pos   = 0;
              m_state = M_FRAME;
            end
          end
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run parameters are scrambled right after the start pulse; the DUT must ignore them
  task automatic apply_stimulus(input int count, input int len, input int pat);
    tick(1);
    frame_count = 16'(count);
    payload_len = 11'(len);
    pattern     = 2'(pat);
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
    frame_count = 16'($urandom);
    payload_len = 11'($urandom);
    pattern     = 2'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check_output({name, "_finished"}, busy, 0);
    tick(3);
  endtask

  task automatic wait_pos(input string name, input int idx, input int pos, input int budget);
    int n = 0;
    while (!(m_state == M_FRAME && m_idx == idx && m_pos == pos) && n < budget) begin
      tick(1);
      n++;
    end
    check_output({name, "_reached"}, n < budget, 1);
  endtask

  task automatic pulse_reset();
    tick(1);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int diff;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // single 72-byte frame with preamble, short payload padded to minimum
    cap.delete();
    apply_stimulus(1, 28, 0);
    wait_idle("t1", 300);
    check_output("t1_len", cap.size(), 72);
    check_output("t1_pre0", cap[0], 8'h55);
    check_output("t1_pre6", cap[6], 8'h55);
    check_output("t1_sfd", cap[7], 8'hD5);
    check_output("t1_da0", cap[8], 8'hFF);
    check_output("t1_sa0", cap[14], 8'h01);
    check_output("t1_sa5", cap[19], 8'h06);
    check_output("t1_type", {cap[20], cap[21]}, 16'h0800);
    check_output("t1_pad", cap[67], 8'h00);
    check_output("t1_residue", residue(cap, 8, cap.size()), 32'hC704_DD7B);
    check_output("t1_sent", sent, 1);

    // three frames, counting pattern, no pad
    cap.delete();
    apply_stimulus(3, 100, 1);
    wait_idle("t2", 1500);
    check_output("t2_len", cap.size(), 378);
    for (int f = 0; f < 3; f++)
      check_output($sformatf("t2_residue f%0d", f), residue(cap, 126 * f + 8, 126 * f + 126), 32'hC704_DD7B);
    check_output("t2_pay_first", cap[22], 8'h00);
    check_output("t2_pay_last", cap[121], 8'h63);
    check_output("t2_sent", sent, 4);
    ref_q = cap;

    // same run under random backpressure must give the identical byte stream
    rdy_rand = 1'b1;
    cap.delete();
    apply_stimulus(3, 100, 1);
    wait_idle("t3", 4000);
    rdy_rand = 1'b0;
    diff = 0;
    for (int i = 0; i < ref_q.size(); i++) if (cap[i] !== ref_q[i]) diff++;
    check_output("t3_len", cap.size(), 378);
    check_output("t3_stream_diff", diff, 0);

    // continuous mode stopped in the middle of frame 5
    pulse_reset();
    cap.delete();
    apply_stimulus(0, 20, 2);
    wait_pos("t4", 5, 30, 2000);
    stop = 1'b1;
    wait_idle("t4", 500);
    stop = 1'b0;
    check_output("t4_sent", sent, 6);
    check_output("t4_len", cap.size(), 432);
    check_output("t4_f0_pay", cap[22], 8'h00);
    check_output("t4_f3_pay", cap[3 * 72 + 30], 8'h03);
    check_output("t4_f5_pay", cap[5 * 72 + 22], 8'h05);

    // asynchronous reset in the payload of frame 1, then a fresh run
    pulse_reset();
    apply_stimulus(3, 100, 1);
    wait_pos("t5", 1, 50, 1000);
    check_output("t5_sent_before", sent, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_async_clear", {data, valid, sof, eof, busy, sent}, 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    cap.delete();
    apply_stimulus(1, 30, 2);
    wait_idle("t5", 300);
    check_output("t5_len", cap.size(), 72);
    check_output("t5_first", cap[0], 8'h55);
    check_output("t5_idx0", cap[22], 8'h00);
    check_output("t5_sent_after", sent, 1);

    // no preamble, oversize length clamped, restart attempt while busy
    sel = 1'b1;
    tick(2);
    cap.delete();
    apply_stimulus(1, 2000, 3);
    tick(100);
    payload_len = 11'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("t6", 3000);
    tick(20);
    check_output("t6_len", cap.size(), 1518);
    check_output("t6_da0", cap[0], 8'hFF);
    check_output("t6_sa0", cap[6], 8'h01);
    check_output("t6_pay_first", cap[14], 8'hA5);
    check_output("t6_pay_last", cap[1513], 8'hA5);
    check_output("t6_residue", residue(cap, 0, cap.size()), 32'hC704_DD7B);
    check_output("t6_sent", sent, 1);
    check_output("t6_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Parametrised Ethernet test-frame generator driving the MAC transmit byte interface (`mac_tx_data/valid/sof/eof`) of `mac_rgmii`.
- Builds complete frames in hardware: optional preamble/SFD, DA/SA/EtherType header, patterned payload, zero padding to minimum size, and CRC32 FCS.
- Supports single-frame, N-frame and continuous modes, with a programmable inter-frame gap and sink backpressure.
- Used for bring-up and loopback of the RGMII path without external traffic.

## Interface
- `DST_MAC`, default 48'hFFFF_FFFF_FFFF: destination address, sent MSB byte first.
- `SRC_MAC`, default 48'h0102_0304_0506: source address, sent MSB byte first.
- `ETHERTYPE`, default 16'h0800: EtherType, sent MSB byte first.
- `PREAMBLE`, default 1: 1 = emit 7×8'h55 + 8'hD5 before DA; 0 = frame starts at DA.
- `GAP`, default 12: idle cycles between frames, valid low; range 1..255.
- `LEN_W`, default 11: width of `payload_len_i`.
- `mac_tx_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle start pulse; sampled only in IDLE.
- `stop_i` in 1: level; finish the current frame, then return to IDLE.
- `frame_count_i` in 16: number of frames; 0 = continuous.
- `payload_len_i` in LEN_W: payload bytes; clamped to 1500.
- `pattern_i` in 2: payload pattern. 0 = zeros; 1 = byte k → k[7:0]; 2 = frame index [7:0]; 3 = 8'hA5.
- `mac_tx_rdy_i` in 1: sink ready.
- `mac_tx_data` out 8: byte.
- `mac_tx_valid` out 1: byte valid.
- `mac_tx_sof` out 1: first byte of frame.
- `mac_tx_eof` out 1: last FCS byte.
- `busy_o` out 1: not IDLE.
- `frames_sent_o` out 32: frames completed since reset; wraps.

## Operation
- States: IDLE → PRE (8 bytes, if PREAMBLE) → HDR (14) → PAY (L) → PAD (max(0, 46−L)) → FCS (4) → GAP → HDR/PRE or IDLE.
- At `start_i` in IDLE, latch `frame_count_i`, clamped length L, and `pattern_i`. Changes to these inputs during a run are ignored.
- Byte transfer occurs when `mac_tx_valid && mac_tx_rdy_i`. Byte counters and the CRC advance only on a transfer. While rdy is low, data/sof/eof are held stable.
- `mac_tx_valid` stays high from the first PRE/HDR byte through the last FCS byte.
- `mac_tx_sof` is high on the first byte: the first 8'h55 if PREAMBLE, else DA[47:40]. `mac_tx_eof` is high on FCS byte 3 only.
- CRC32: polynomial 0x04C11DB7, initialised to 32'hFFFFFFFF at HDR entry, computed over HDR+PAY+PAD bytes.
  - FCS = bit-reverse(~crc), sent bits [7:0] first, then [15:8], [23:16], [31:24].
  - Preamble/SFD bytes are excluded from the CRC.
- Frame index runs 0,1,2… within a run. `frames_sent_o` increments on the eof transfer.
- After each eof transfer:
  - If `stop_i` is high, or the count has been reached (count ≠ 0), go to IDLE with no GAP.
  - Otherwise go to GAP.
- GAP counts GAP cycles, independent of rdy.
- `stop_i` never truncates a frame. If `stop_i` is asserted during GAP, exit to IDLE at the end of the gap.
- `start_i` while busy is ignored. If `start_i` and `stop_i` are both high in IDLE, start wins and stop takes effect at the first eof.
- L=0 produces a frame with 46 pad bytes.

## Timing
- Reset values: `mac_tx_data`=0, `mac_tx_valid`=0, `mac_tx_sof`=0, `mac_tx_eof`=0, `busy_o`=0, `frames_sent_o`=0, state IDLE.
- Reset mid-frame clears all outputs immediately (async). No partial frame resumes.
- Latency: `start_i` at cycle n → first byte valid, with sof, at cycle n+1. `busy_o` is high from n+1.
- All outputs are registered.
- With rdy constantly high, frame occupies 8·PREAMBLE + 18 + max(L,46) cycles, followed by GAP idle cycles.
- `busy_o` drops the cycle after the final eof transfer, or the cycle after the last GAP cycle on a stop-in-gap exit.

## Test plan
- PREAMBLE=1, L=28, pattern 0, count 1, rdy=1:
  - 72 valid bytes: 55×7, D5, FF×6, 01..06, 08 00, 46×00, 4 FCS bytes.
  - sof on byte 0, eof on byte 71.
  - Bench CRC model run over DA..FCS gives residue 32'hC704DD7B.
  - `frames_sent_o`=1, then IDLE.
- L=100, pattern 1, count 3, GAP=12:
  - Three 126-byte frames with exactly 12 valid-low cycles between them.
  - Payload bytes 00..63; no pad; every frame's CRC residue is correct.
- rdy toggling pseudo-randomly at 50%:
  - Byte stream is identical to the rdy=1 run.
  - data/sof/eof hold while rdy low; no byte is lost or duplicated.
- Continuous mode (count 0), pattern 2, `stop_i` raised mid-frame 5:
  - Frame 5 completes with eof, then IDLE.
  - Payload of frame k is all k; `frames_sent_o`=6.
- `rst_n` low during PAY of frame 1:
  - All outputs 0 at once; `frames_sent_o`=0.
  - A new start after release begins a fresh frame with sof and frame index 0.
- L=2000, PREAMBLE=0, pattern 3:
  - Length clamped to 1500; 1518 bytes.
  - sof on DA[47:40]=FF; payload all A5; start pulse while busy ignored.
